// File: rtl/mips_cpu_muldiv_if.sv
// mips_cpu_muldiv_if: request/response bundle between EX-stage control and the
// multiply/divide unit. The master drives the operation request; the slave
// (the unit) returns status and the architectural HI/LO values.
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers,
// plus single-edge MTHI/MTLO writes.
// Iterative ops run on operand magnitudes (radix-2 shift-add multiply,
// restoring divide), then get a sign-correction cycle and a commit edge, so
// done rises WIDTH+2 edges after the start edge.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU bypass the iteration and
// use one combinational WIDTH x WIDTH product (done 2 edges after start).
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  mips_cpu_muldiv_if.slave   bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // S_WB is the commit edge that follows the sign-correction cycle in S_FIX.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WB} state_t;

  // Two's-complement negate of a WIDTH-bit value when sgn is set.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn) begin
      return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

  state_t           r_state;
  logic             r_is_div;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_mb;
  logic [WIDTH-1:0] r_ph;
  logic [WIDTH-1:0] r_pl;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_res_div0;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic             r_div0;
  logic             r_mt_pend;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_nph;
  logic [WIDTH-1:0]   w_npl;
  logic [2*WIDTH-1:0] w_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;
  logic               w_res_div0;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_sa;
  logic               w_sb;

  // Operand signs and magnitudes at the start edge; unsigned ops have no sign.
  always_comb begin
    w_sa    = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) ? bus.a[WIDTH-1] : 1'b0;
    w_sb    = ((bus.op == OP_MULT) || (bus.op == OP_DIV)) ? bus.b[WIDTH-1] : 1'b0;
    w_abs_a = cond_neg(bus.a, w_sa);
    w_abs_b = cond_neg(bus.b, w_sb);
  end

  // One iteration step: {r_ph,r_pl} is product-so-far/multiplier for mul,
  // partial remainder/dividend-becoming-quotient for div.
  always_comb begin
    w_sum   = {1'b0, r_ph} + {1'b0, r_mb};
    w_shift = {r_ph, r_pl[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_mb};
    w_nph   = r_ph;
    w_npl   = r_pl;
    if (r_is_div) begin
      if (!w_diff[WIDTH]) begin
        w_nph = w_diff[WIDTH-1:0];
        w_npl = {r_pl[WIDTH-2:0], 1'b1};
      end else begin
        w_nph = w_shift[WIDTH-1:0];
        w_npl = {r_pl[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (r_pl[0]) begin
        w_nph = w_sum[WIDTH:1];
        w_npl = {w_sum[0], r_pl[WIDTH-1:1]};
      end else begin
        w_nph = {1'b0, r_ph[WIDTH-1:1]};
        w_npl = {r_ph[0], r_pl[WIDTH-1:1]};
      end
    end
  end

  // Sign correction of the magnitude result, including the divide-by-zero pattern.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    if (r_is_div) begin
      w_mag = {r_ph, r_pl};
    end else begin
      w_mag = {{WIDTH{1'b0}}, r_pl} * {{WIDTH{1'b0}}, r_mb};
    end
`else
    w_mag = {r_ph, r_pl};
`endif
    w_prod     = w_mag;
    w_res_hi   = r_ph;
    w_res_lo   = r_pl;
    w_res_div0 = 1'b0;
    if (r_is_div) begin
      if (r_mb == {WIDTH{1'b0}}) begin
        w_res_lo   = {WIDTH{1'b1}};
        w_res_hi   = r_a;
        w_res_div0 = 1'b1;
      end else begin
        w_res_lo = cond_neg(w_mag[WIDTH-1:0], r_sa ^ r_sb);
        w_res_hi = cond_neg(w_mag[2*WIDTH-1:WIDTH], r_sa);
      end
    end else begin
      if (r_sa ^ r_sb) begin
        w_prod = ~w_mag + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
        w_prod = w_mag;
      end
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_is_div   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_a        <= {WIDTH{1'b0}};
      r_mb       <= {WIDTH{1'b0}};
      r_ph       <= {WIDTH{1'b0}};
      r_pl       <= {WIDTH{1'b0}};
      r_cnt      <= {CW{1'b0}};
      r_res_hi   <= {WIDTH{1'b0}};
      r_res_lo   <= {WIDTH{1'b0}};
      r_res_div0 <= 1'b0;
      r_hi       <= {WIDTH{1'b0}};
      r_lo       <= {WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div0     <= 1'b0;
      r_mt_pend  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_mt_pend <= 1'b0;
      // An MTxx completes one edge after its write; it clears the divide flag.
      if (r_mt_pend) begin
        r_done <= 1'b1;
        r_div0 <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_is_div <= bus.op[1];
                r_sa     <= w_sa;
                r_sb     <= w_sb;
                r_a      <= bus.a;
                r_mb     <= w_abs_b;
                r_ph     <= {WIDTH{1'b0}};
                r_pl     <= w_abs_a;
                r_cnt    <= {CW{1'b0}};
                r_busy   <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                r_state  <= bus.op[1] ? S_CALC : S_FIX;
`else
                r_state  <= S_CALC;
`endif
              end
              OP_MTHI: begin
                r_hi      <= bus.a;
                r_mt_pend <= 1'b1;
              end
              OP_MTLO: begin
                r_lo      <= bus.a;
                r_mt_pend <= 1'b1;
              end
              default: begin
                r_state <= S_IDLE;
              end
            endcase
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_ph  <= w_nph;
            r_pl  <= w_npl;
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            if (r_cnt == LAST) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_res_hi   <= w_res_hi;
            r_res_lo   <= w_res_lo;
            r_res_div0 <= w_res_div0;
            r_state    <= S_WB;
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!bus.flush) begin
            r_hi   <= r_res_hi;
            r_lo   <= r_res_lo;
            r_div0 <= r_res_div0;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: randomized and directed checks of mips_cpu_muldiv
// against an arithmetic reference model (64-bit products and quotients).
module tb_mips_cpu_muldiv;
  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always #5 clk = ~clk;

  mips_cpu_muldiv_if #(.WIDTH(W)) bus ();
  mips_cpu_muldiv #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference: MIPS mult/div semantics via wide integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic ez);
    longint sx, sy, q, r;
    logic [63:0] p;
    ez = 1'b0;
    sx = $signed(x);
    sy = $signed(y);
    if (o == 3'd0) begin
      p = 64'(sx * sy);
      eh = p[63:32]; el = p[31:0];
    end else if (o == 3'd1) begin
      p = {32'd0, x} * {32'd0, y};
      eh = p[63:32]; el = p[31:0];
    end else if (y == 32'd0) begin
      el = 32'hFFFF_FFFF; eh = x; ez = 1'b1;
    end else begin
      if (o == 3'd2) begin
        q = sx / sy; r = sx % sy;
      end else begin
        q = longint'({32'd0, x}) / longint'({32'd0, y});
        r = longint'({32'd0, x}) % longint'({32'd0, y});
      end
      el = q[31:0]; eh = r[31:0];
    end
  endfunction

  // Issue one op from a negedge; returns edges-to-done and busy cycles seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int busy_cyc);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; busy_cyc = 0;
    if (bus.busy) busy_cyc++;
    if (bus.done) lat = 0;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) lat = k;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.div0 !== 1'b0) begin n_err++; $display("FAIL reset_div0 got=%b exp=0", bus.div0); end
    n_checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_err++; $display("FAIL reset_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); end
  endtask

  task automatic test_mul;
    int lat, bc;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    n_checks++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL multu_lat got=%0d exp=%0d", lat, MUL_LAT); end
    n_checks++; if (bc !== MUL_LAT) begin n_err++; $display("FAIL multu_busy got=%0d exp=%0d", bc, MUL_LAT); end
    n_checks++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_res got=%h/%h exp=fffffffe/00000001", bus.hi, bus.lo); end
    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, lat, bc);
    n_checks++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_res got=%h/%h exp=ffffffff/fffffffa", bus.hi, bus.lo); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFFA;
    // MTHI: hi visible right after the start edge, done one edge later.
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h1234_5678;
    @(posedge clk); #1;
    n_checks++; if (bus.hi !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi got=%h exp=12345678", bus.hi); end
    n_checks++; if (bus.lo !== exp_lo || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL mthi_edge0 got lo=%h busy=%b done=%b exp lo=%h busy=0 done=0", bus.lo, bus.busy, bus.done, exp_lo); end
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b1 || bus.div0 !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL mthi_done got done=%b div0=%b busy=%b exp 1/0/0", bus.done, bus.div0, bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mthi_pulse got=%b exp=0", bus.done); end
    exp_hi = 32'h1234_5678;
  endtask

  task automatic test_div;
    int lat, bc;
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, lat, bc);
    n_checks++; if (lat !== DIV_LAT) begin n_err++; $display("FAIL div_lat got=%0d exp=%0d", lat, DIV_LAT); end
    n_checks++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_neg got=%h/%h exp=ffffffff/fffffffd", bus.hi, bus.lo); end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    n_checks++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0 || bus.div0 !== 1'b0) begin n_err++; $display("FAIL div_ovf got=%h/%h div0=%b exp=00000000/80000000 div0=0", bus.hi, bus.lo, bus.div0); end
    run_op(3'd3, 32'h0000_0007, 32'h0, lat, bc);
    n_checks++; if (lat !== DIV_LAT || bus.div0 !== 1'b1) begin n_err++; $display("FAIL divu_zero got lat=%0d div0=%b exp lat=%0d div0=1", lat, bus.div0, DIV_LAT); end
    n_checks++; if (bus.lo !== 32'hFFFF_FFFF || bus.hi !== 32'h7) begin n_err++; $display("FAIL divu_zero_res got=%h/%h exp=00000007/ffffffff", bus.hi, bus.lo); end
    @(negedge clk);
    n_checks++; if (bus.div0 !== 1'b1) begin n_err++; $display("FAIL div0_hold got=%b exp=1", bus.div0); end
    run_op(3'd3, 32'h7, 32'h2, lat, bc);
    n_checks++; if (bus.div0 !== 1'b0 || bus.lo !== 32'h3 || bus.hi !== 32'h1) begin n_err++; $display("FAIL divu_7_2 got=%h/%h div0=%b exp=1/3 div0=0", bus.hi, bus.lo, bus.div0); end
    run_op(3'd3, 32'h9, 32'h0, lat, bc);
    // MTLO after a divide-by-zero completion clears div0 on its done.
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h55;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.done !== 1'b1 || bus.div0 !== 1'b0 || bus.lo !== 32'h55 || bus.hi !== 32'h9) begin n_err++; $display("FAIL mtlo_clr got done=%b div0=%b hi=%h lo=%h exp 1/0/9/55", bus.done, bus.div0, bus.hi, bus.lo); end
    exp_hi = 32'h9; exp_lo = 32'h55;
  endtask

  task automatic test_random;
    int lat, bc, elat;
    logic [2:0] o;
    logic [31:0] x, y, eh, el;
    logic ez;
    logic [31:0] corner [5];
    corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 15));
      model(o, x, y, eh, el, ez);
      elat = o[1] ? DIV_LAT : MUL_LAT;
      run_op(o, x, y, lat, bc);
      n_checks++;
      if (lat !== elat || bus.hi !== eh || bus.lo !== el || bus.div0 !== ez) begin
        n_err++;
        $display("FAIL rand op=%0d a=%h b=%h got lat=%0d hi=%h lo=%h div0=%b exp lat=%0d hi=%h lo=%h div0=%b",
                 o, x, y, lat, bus.hi, bus.lo, bus.div0, elat, eh, el, ez);
      end
      exp_hi = eh; exp_lo = el;
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    run_op(3'd1, 32'd3, 32'd4, lat, bc);
    // Next start is driven in the very cycle done is high.
    n_checks++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%b exp=1", bus.done); end
    run_op(3'd2, 32'd100, 32'hFFFF_FFF9, lat, bc);
    n_checks++; if (lat !== DIV_LAT || bus.lo !== 32'hFFFF_FFF2 || bus.hi !== 32'h2) begin n_err++; $display("FAIL b2b_div got lat=%0d %h/%h exp lat=%0d 00000002/fffffff2", lat, bus.hi, bus.lo, DIV_LAT); end
    exp_hi = 32'h2; exp_lo = 32'hFFFF_FFF2;
  endtask

  task automatic test_flush;
    int seen_done;
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk); bus.start = 1'b0;          // after edge 0
    repeat (4) @(negedge clk);                  // after edge 4
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd2; bus.b = 32'd2;
    @(negedge clk); bus.start = 1'b0;          // after edge 5
    repeat (4) @(negedge clk);                  // after edge 9
    n_checks++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL flush_inflight got busy=%b exp=1", bus.busy); end
    bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;          // after edge 10
    n_checks++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done !== 0) begin n_err++; $display("FAIL flush_nodone got=%0d active cycles exp=0", seen_done); end
    n_checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin n_err++; $display("FAIL flush_hilo got=%h/%h exp=%h/%h", bus.hi, bus.lo, exp_hi, exp_lo); end
    // flush with a simultaneous MTHI in idle, then an unused op code.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd4; bus.a = 32'hDEAD_BEEF;
    @(negedge clk); bus.flush = 1'b0; bus.op = 3'd6;
    @(negedge clk); bus.op = 3'd7;
    @(negedge clk); bus.start = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done++;
    end
    n_checks++; if (seen_done !== 0 || bus.hi !== exp_hi || bus.lo !== exp_lo) begin n_err++; $display("FAIL ignored_ops got active=%0d hi=%h lo=%h exp 0 %h %h", seen_done, bus.hi, bus.lo, exp_hi, exp_lo); end
  endtask

  task automatic test_async_reset;
    int lat, bc;
    run_op(3'd3, 32'd7, 32'd0, lat, bc);   // leaves div0=1 and nonzero hi/lo
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk); bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.div0 !== 1'b0) begin n_err++; $display("FAIL areset_ctl got busy=%b done=%b div0=%b exp 0/0/0", bus.busy, bus.done, bus.div0); end
    n_checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_err++; $display("FAIL areset_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    run_op(3'd1, 32'd3, 32'd5, lat, bc);
    n_checks++; if (lat !== MUL_LAT || bus.lo !== 32'h0000_000F || bus.hi !== 32'd0) begin n_err++; $display("FAIL post_reset got lat=%0d %h/%h exp lat=%0d 00000000/0000000f", lat, bus.hi, bus.lo, MUL_LAT); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_random();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
